nand_chain_tester: RTL

- Self-checking exhaustive stimulus/response block for the 3-stage NAND chain (E=~(A&B), F=~(E&C), G=~(F&D)); sits on the opposite end of that interface.
- Drives the chain's A..D inputs and samples its E, F and G nodes.
- On `start`, walks all 16 input vectors, compares the sampled nodes against internally computed expected values, and reports pass/fail plus first-failure diagnostics.
- Used on the lab board and in simulation to verify the chain.

---
 rtl/nand_chain_tester.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nand_chain_tester.sv
// rtl/nand_chain_tester.sv - exhaustive stimulus/response checker for a 3-stage NAND chain
`timescale 1ns/1ps
module nand_chain_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail_vec,
    output logic [2:0] first_fail_mask
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [3:0] vec;
    logic [3:0] settle_cnt;
    logic       exp_e;
    logic       exp_f;
    logic       exp_g;
    logic [2:0] mask;
    logic       accept;
    logic       do_check;
    logic       in_sweep;
    logic       hold_done;

    assign A = vec[3];
    assign B = vec[2];
    assign C = vec[1];
    assign D = vec[0];

    assign exp_e = ~(vec[3] & vec[2]);
    assign exp_f = ~(exp_e & vec[1]);
    assign exp_g = ~(exp_f & vec[0]);
    assign mask  = {E ^ exp_e, F ^ exp_f, G ^ exp_g};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_APPLY;
            S_APPLY:  state_nx = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            S_SETTLE: if (settle_cnt <= 4'd1) state_nx = S_CHECK;
            S_CHECK:  state_nx = (vec == 4'hF) ? S_DONE : S_APPLY;
            S_DONE:   if (start) state_nx = S_APPLY;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = ((state == S_IDLE) || (state == S_DONE)) && start;
        do_check  = (state == S_CHECK);
        in_sweep  = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
        hold_done = (state == S_DONE) && !start;
    end

    // Status outputs are registered, so they trail the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec             <= 4'd0;
            settle_cnt      <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 5'd0;
            fail_valid      <= 1'b0;
            first_fail_vec  <= 4'd0;
            first_fail_mask <= 3'd0;
        end else begin
            busy <= in_sweep;

            if (accept) begin
                vec             <= 4'd0;
                done            <= 1'b0;
                pass            <= 1'b0;
                err_count       <= 5'd0;
                fail_valid      <= 1'b0;
                first_fail_vec  <= 4'd0;
                first_fail_mask <= 3'd0;
            end else if (hold_done) begin
                done <= 1'b1;
                pass <= (err_count == 5'd0);
            end

            if (state == S_APPLY) begin
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == S_SETTLE) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            // vec wraps 15 -> 0 on the final check.
            if (do_check) begin
                vec <= vec + 4'd1;
                if (mask != 3'd0) begin
                    err_count <= err_count + 5'd1;
                    if (!fail_valid) begin
                        fail_valid      <= 1'b1;
                        first_fail_vec  <= vec;
                        first_fail_mask <= mask;
                    end
                end
            end
        end
    end

endmodule
